qpsk_symbol_mapper: RTL and testbench
=====================================

Name: qpsk_symbol_mapper

Overview:
- Upstream neighbour of the pulse-shaping filter in the RFNoC QPSK transmit chain.
- Consumes packed 32-bit bit words and maps each dibit to a Gray-coded QPSK sc16 symbol.
- Zero-stuffs each symbol by a runtime samples-per-symbol factor, so the downstream filter sees an impulse train at the interpolated rate.
- Sits inside the block's user logic between the AXI-Stream payload unpacker and the pulse-shaping filter input.

Parameters:
- AMP, 16'sd11585 — signed symbol magnitude applied to I and Q (0.7071 in Q1.14).
- SPS_W, 8 — width of the samples-per-symbol control input.

Ports:
- ce_clk  in  1  block clock; all logic on rising edge.
- ce_rst  in  1  reset, asynchronous, active-high.
- cfg_sps  in  SPS_W  output samples per symbol; 0 is treated as 1.
- s_axis_tdata  in  32  packed bits; dibit order MSB first ([31:30] first, [1:0] last).
- s_axis_tlast  in  1  end of input packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  32  sc16 sample; I in [31:16], Q in [15:0].
- m_axis_tlast  out  1  end of output packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- busy  out  1  high while a word is held (not yet fully emitted).

Behaviour:
- Reset values (asynchronous on ce_rst=1):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, busy=0, s_axis_tready=0 while in reset.
  - All counters and the held word cleared.
  - A partially emitted word is discarded.
  - s_axis_tready=1 on the first clock edge after deassertion.
- Input acceptance:
  - A word is accepted on s_axis_tvalid & s_axis_tready.
  - On acceptance the block latches the word, tlast, and sps_l = max(cfg_sps,1).
  - cfg_sps changes take effect only at the next word acceptance.
- State machine:
  - IDLE: no word held; s_axis_tready=1. On acceptance go to EMIT with dibit_idx=0, phase=0.
  - EMIT: the output register presents a sample whenever m_axis_tvalid=1.
- Sample generation:
  - Sample at phase 0: symbol for the dibit at dibit_idx, where b1 is the even (upper) bit.
    - I = b1 ? -AMP : +AMP
    - Q = b0 ? -AMP : +AMP
    - Mapping: 00→(+,+), 01→(+,−), 11→(−,−), 10→(−,+).
  - Samples at phase 1..sps_l−1: 32'h0000_0000.
  - -AMP is computed as two's complement; no saturation is needed because AMP < 2^15.
- Advance rule (only on m_axis_tvalid & m_axis_tready):
  - phase increments.
  - On phase = sps_l−1: phase wraps to 0 and dibit_idx increments.
  - On dibit_idx=15 with phase=sps_l−1: the word is complete.
- tlast:
  - m_axis_tlast=1 only on the final sample (dibit 15, last phase) of a word latched with tlast=1; 0 otherwise.
- Handshake:
  - m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 & m_axis_tready=0.
  - m_axis_tvalid never drops without a transfer.
- Back-to-back:
  - s_axis_tready = ~busy | (final sample transferring this cycle).
  - A new word can load in the same cycle the last sample leaves, so the output streams with no bubble.
- Latency:
  - First sample of a word is valid on the cycle after acceptance.
  - Throughput is exactly 16·sps_l output samples per input word.
- busy:
  - Set on acceptance.
  - Cleared on final-sample transfer unless a new word is accepted in the same cycle.
- Reset mid-word: output goes idle immediately; no tlast is emitted for the discarded word.

Test Plan:
- Reset → m_axis_tvalid=0; s_axis_tready=1 one cycle after release.
- cfg_sps=1, word 32'h1B1B_1B1B, tlast=1 → 16 samples, repeating the dibit pattern 00,01,10,11:
  - 2D41_2D41, 2D41_D2BF, D2BF_2D41, D2BF_D2BF, …
  - tlast only on sample 15.
- cfg_sps=4, word 32'h0000_0000 → 64 samples: 2D41_2D41 at indices 0,4,…,60, zeros elsewhere; busy low after sample 63.
- cfg_sps=0 → behaves identically to cfg_sps=1 (16 samples per word).
- Two words with tvalid held, m_axis_tready=1 constantly, cfg_sps=2 → 64 contiguous valid cycles with no bubble; tlast only on the second word's last sample if set.
- Random m_axis_tready stalls (25%) → data/tlast held stable while stalled; output sequence identical to the no-stall run.
- Change cfg_sps 2→3 mid-word → current word completes at sps 2, next word uses 3.
- ce_rst asserted mid-word → tvalid drops asynchronously; the next word starts at dibit 0.

Source files
------------

// File: rtl/qpsk_symbol_mapper.sv
// QPSK symbol mapper with zero-stuffing interpolation.
// Unpacks 32-bit words into 16 dibits (MSB first), maps each to a Gray-coded
// sc16 QPSK point and follows it with sps-1 zero samples so the downstream
// pulse-shaping filter sees an impulse train at the interpolated rate.
module qpsk_symbol_mapper #(
  parameter logic signed [15:0] AMP   = 16'sd11585,
  parameter int                 SPS_W = 8
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic [SPS_W-1:0] cfg_sps,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             busy
);

  localparam logic [SPS_W-1:0] ONE = {{(SPS_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             rst_done_reg;
  logic [31:0]      word_reg;
  logic             last_reg;
  logic [SPS_W-1:0] sps_reg;
  logic [SPS_W-1:0] phase_reg;
  logic [3:0]       dibit_reg;

  logic             phase_last;
  logic             final_sample;
  logic             xfer;
  logic             accept;
  logic [SPS_W-1:0] sps_in;
  logic [1:0]       dibits [16];
  logic [1:0]       sym;
  logic signed [15:0] neg_amp;
  logic [15:0]      i_val;
  logic [15:0]      q_val;

  // Split the held word into its 16 dibits, dibit 0 being bits [31:30].
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_dibit
      assign dibits[gi] = word_reg[31-2*gi -: 2];
    end
  endgenerate

  assign busy          = (state_reg == EMIT);
  assign phase_last    = (phase_reg == sps_reg - ONE);
  assign final_sample  = busy & (dibit_reg == 4'hF) & phase_last;
  assign xfer          = busy & m_axis_tready;
  // A new word may load in the same cycle the final sample leaves; tready is
  // held low until the first clock edge after reset release.
  assign s_axis_tready = rst_done_reg & (~busy | (xfer & final_sample));
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign sps_in        = (cfg_sps == '0) ? ONE : cfg_sps;

  // Gray mapping: upper bit of the dibit selects the sign of I, lower of Q.
  assign sym     = dibits[dibit_reg];
  assign neg_amp = -AMP;
  assign i_val   = sym[1] ? neg_amp : AMP;
  assign q_val   = sym[0] ? neg_amp : AMP;

  // Output is derived from registered state only, so it holds while stalled
  // and drops to idle immediately when reset clears the state register.
  assign m_axis_tvalid = busy;
  assign m_axis_tdata  = (busy && phase_reg == '0) ? {i_val, q_val} : 32'h0000_0000;
  assign m_axis_tlast  = final_sample & last_reg;

  // State register and ready-after-reset flag.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state_reg    <= IDLE;
      rst_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rst_done_reg <= 1'b1;
    end
  end

  // Next-state logic: leave EMIT only when the final sample goes out with no
  // replacement word arriving in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = EMIT;
      EMIT: if (xfer && final_sample && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word capture and dibit/phase counters.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      word_reg  <= 32'h0000_0000;
      last_reg  <= 1'b0;
      sps_reg   <= ONE;
      phase_reg <= '0;
      dibit_reg <= 4'd0;
    end else if (accept) begin
      word_reg  <= s_axis_tdata;
      last_reg  <= s_axis_tlast;
      sps_reg   <= sps_in;
      phase_reg <= '0;
      dibit_reg <= 4'd0;
    end else if (xfer) begin
      if (phase_last) begin
        phase_reg <= '0;
        dibit_reg <= dibit_reg + 4'd1;
      end else begin
        phase_reg <= phase_reg + ONE;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Self-checking bench for qpsk_symbol_mapper: a queue-based model expands each
// accepted word into its expected sample stream and a monitor compares every
// output transfer against it; directed tests pin literal values.
module tb_qpsk_symbol_mapper;

  localparam int AMP_I = 11585;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic [7:0]  cfg_sps = 8'd1;
  logic [31:0] s_axis_tdata = 32'h0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        busy;

  qpsk_symbol_mapper dut (
    .ce_clk        (ce_clk),
    .ce_rst        (ce_rst),
    .cfg_sps       (cfg_sps),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy)
  );

  always #5 ce_clk = ~ce_clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          cyc;
  } rec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          stall_en = 0;
  logic [32:0] exp_q [$];
  rec_t        out_log [$];
  rec_t        ref_log [$];
  bit          prev_stall = 0;
  logic [31:0] prev_data = 32'h0;
  logic        prev_last = 1'b0;

  always @(posedge ce_clk) cyc <= cyc + 1;

  // Downstream ready: always 1, or random with 25% stalls.
  always @(posedge ce_clk) begin
    #1;
    m_axis_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Expected stream for one word: each dibit gives one QPSK point followed by sps-1 zeros.
  function automatic void model_word(input logic [31:0] d, input logic l, input int sps);
    for (int k = 0; k < 16; k++) begin
      logic [1:0]  s;
      logic [15:0] iv;
      logic [15:0] qv;
      s  = 2'((d >> (30 - 2 * k)) & 32'h3);
      iv = s[1] ? 16'(-AMP_I) : 16'(AMP_I);
      qv = s[0] ? 16'(-AMP_I) : 16'(AMP_I);
      for (int p = 0; p < sps; p++) begin
        exp_q.push_back({(l && k == 15 && p == sps - 1), (p == 0) ? {iv, qv} : 32'h0});
      end
    end
  endfunction

  // Monitor: hold-stability, acceptance into the model, and output comparison.
  always @(negedge ce_clk) begin
    if (ce_rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          errors++;
          $display("FAIL hold got v=%0d %h/%0d expected v=1 %h/%0d",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (s_axis_tvalid && s_axis_tready)
        model_word(s_axis_tdata, s_axis_tlast, (cfg_sps == 0) ? 1 : int'(cfg_sps));
      if (m_axis_tvalid && m_axis_tready) begin
        logic [32:0] e;
        rec_t r;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sample got %h/%0d expected no sample", m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e[31:0] || m_axis_tlast !== e[32]) begin
            errors++;
            $display("FAIL sample got %h/%0d expected %h/%0d",
                     m_axis_tdata, m_axis_tlast, e[31:0], e[32]);
          end
        end
        r.data = m_axis_tdata;
        r.last = m_axis_tlast;
        r.cyc  = cyc;
        out_log.push_back(r);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    bit acc;
    acc = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      @(negedge ce_clk);
      if (s_axis_tready) begin
        acc = 1;
        break;
      end
    end
    @(posedge ce_clk);
    #1;
    s_axis_tvalid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout got tready=0 expected 1 within 5000 cycles");
    end
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int n = 0; n < 5000; n++) begin
      @(posedge ce_clk);
      #2;
      if (!busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout got busy=%0d pending=%0d expected idle", busy, exp_q.size());
    end
  endtask

  task automatic wait_log(input int n_samples);
    bit done;
    done = 0;
    for (int n = 0; n < 5000; n++) begin
      @(posedge ce_clk);
      #2;
      if (out_log.size() >= n_samples) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL log_timeout got %0d samples expected %0d", out_log.size(), n_samples);
    end
  endtask

  function automatic logic [31:0] log_data(input int idx);
    return (idx < out_log.size()) ? out_log[idx].data : 32'hXXXX_XXXX;
  endfunction

  function automatic logic [31:0] log_last(input int idx);
    return (idx < out_log.size()) ? {31'h0, out_log[idx].last} : 32'hXXXX_XXXX;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;

    // Reset state.
    repeat (2) @(posedge ce_clk);
    #1;
    chk("rst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    chk("rst_tready", {31'h0, s_axis_tready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    ce_rst = 1'b0;
    #2;
    chk("tready_pre_edge", {31'h0, s_axis_tready}, 32'h0);
    @(posedge ce_clk);
    #1;
    chk("tready_post_edge", {31'h0, s_axis_tready}, 32'h1);

    // sps=1, dibit pattern 00,01,10,11 repeating.
    cfg_sps = 8'd1;
    out_log.delete();
    send_word(32'h1B1B_1B1B, 1'b1);
    wait_done();
    chk("t1_count", out_log.size(), 32'd16);
    chk("t1_s0", log_data(0), 32'h2D41_2D41);
    chk("t1_s1", log_data(1), 32'h2D41_D2BF);
    chk("t1_s2", log_data(2), 32'hD2BF_2D41);
    chk("t1_s3", log_data(3), 32'hD2BF_D2BF);
    chk("t1_s4", log_data(4), 32'h2D41_2D41);
    chk("t1_last14", log_last(14), 32'h0);
    chk("t1_last15", log_last(15), 32'h1);

    // sps=4, zero word.
    cfg_sps = 8'd4;
    out_log.delete();
    send_word(32'h0000_0000, 1'b0);
    wait_log(64);
    chk("t2_busy_after", {31'h0, busy}, 32'h0);
    wait_done();
    chk("t2_count", out_log.size(), 32'd64);
    chk("t2_s0", log_data(0), 32'h2D41_2D41);
    chk("t2_s1", log_data(1), 32'h0);
    chk("t2_s3", log_data(3), 32'h0);
    chk("t2_s60", log_data(60), 32'h2D41_2D41);
    chk("t2_last63", log_last(63), 32'h0);

    // sps=0 behaves as sps=1.
    cfg_sps = 8'd0;
    out_log.delete();
    send_word(32'hE4E4_E4E4, 1'b1);
    wait_done();
    chk("t3_count", out_log.size(), 32'd16);
    chk("t3_s0", log_data(0), 32'hD2BF_D2BF);
    chk("t3_s1", log_data(1), 32'hD2BF_2D41);
    chk("t3_last15", log_last(15), 32'h1);

    // Back-to-back words at sps=2, no bubble.
    cfg_sps = 8'd2;
    out_log.delete();
    send_word(32'h9C3A_51E7, 1'b0);
    send_word(32'h2468_ACE1, 1'b1);
    wait_done();
    chk("t4_count", out_log.size(), 32'd64);
    if (out_log.size() == 64)
      chk("t4_span", out_log[63].cyc - out_log[0].cyc, 32'd63);
    chk("t4_last31", log_last(31), 32'h0);
    chk("t4_last63", log_last(63), 32'h1);
    ref_log = out_log;

    // Same words with random downstream stalls.
    stall_en = 1;
    out_log.delete();
    send_word(32'h9C3A_51E7, 1'b0);
    send_word(32'h2468_ACE1, 1'b1);
    wait_done();
    stall_en = 0;
    chk("t5_count", out_log.size(), 32'd64);
    mism = 0;
    for (int i = 0; i < 64 && i < out_log.size() && i < ref_log.size(); i++)
      if (out_log[i].data !== ref_log[i].data || out_log[i].last !== ref_log[i].last) mism++;
    chk("t5_vs_nostall", mism, 32'd0);

    // cfg_sps change 2->3 while a word is in flight.
    cfg_sps = 8'd2;
    out_log.delete();
    send_word(32'h1B1B_1B1B, 1'b0);
    cfg_sps = 8'd3;
    send_word(32'hFFFF_FFFF, 1'b1);
    wait_done();
    chk("t6_count", out_log.size(), 32'd80);
    chk("t6_s2", log_data(2), 32'h2D41_D2BF);
    chk("t6_s34", log_data(34), 32'h0);
    chk("t6_s35", log_data(35), 32'hD2BF_D2BF);
    chk("t6_last79", log_last(79), 32'h1);

    // Reset in the middle of a word.
    cfg_sps = 8'd3;
    out_log.delete();
    send_word(32'hFFFF_FFFF, 1'b1);
    repeat (10) @(posedge ce_clk);
    #3;
    ce_rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t7_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
    chk("t7_busy", {31'h0, busy}, 32'h0);
    chk("t7_tlast", {31'h0, m_axis_tlast}, 32'h0);
    chk("t7_tready", {31'h0, s_axis_tready}, 32'h0);
    repeat (2) @(posedge ce_clk);
    #1;
    ce_rst = 1'b0;
    @(posedge ce_clk);
    #1;
    cfg_sps = 8'd1;
    out_log.delete();
    send_word(32'h1B1B_1B1B, 1'b0);
    wait_done();
    chk("t7_count", out_log.size(), 32'd16);
    chk("t7_s0", log_data(0), 32'h2D41_2D41);
    chk("t7_s1", log_data(1), 32'h2D41_D2BF);
    chk("t7_last15", log_last(15), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
